fwft_sync_fifo: RTL and testbench
=================================

# fwft_sync_fifo

Single-clock, first-word-fall-through (FWFT) FIFO used as the standard buffering element between pipeline stages of the event engine. The oldest stored word is always presented on `dout` without a read request. `rd_en` acts as an acknowledge that pops that word. Occupancy is exported for flow control and debug.

## Interface
Parameters:
- `WIDTH`, default 32: data word width in bits.
- `DEPTH_LOG2`, default 4: log2 of storage depth (depth = 16 words by default).

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `wr_en`  input  1  write request; `din` is pushed when accepted.
- `din`  input  `WIDTH`  write data.
- `full`  output  1  high when occupancy equals depth.
- `rd_en`  input  1  pop/acknowledge of the word currently on `dout`.
- `dout`  output  `WIDTH`  oldest stored word, valid whenever `empty` is low.
- `empty`  output  1  high when occupancy is 0.
- `data_count`  output  `DEPTH_LOG2+1`  current occupancy, 0 to depth inclusive (5 bits by default).

## Operation
- Storage is a circular register array of 2^`DEPTH_LOG2` words, with write pointer `wp`, read pointer `rp` (`DEPTH_LOG2` bits each) and an occupancy counter.
- A write is accepted iff `wr_en` is high and `full` is low at the edge. An accepted write stores `din` at `wp` and increments `wp` modulo depth.
- A read is accepted iff `rd_en` is high and `empty` is low at the edge. An accepted read increments `rp` modulo depth.
- Rejected operations have no effect:
  - A write while full drops the data; stored contents are unchanged.
  - A read while empty does nothing.
  - There is no error output.
- Acceptance of each operation uses the pre-edge flags:
  - Simultaneous read and write when full: the read is accepted and the write is rejected.
  - Simultaneous read and write when empty: the write is accepted and the read is rejected.
  - Otherwise, with both accepted, the count is unchanged.
- Count update: +1 for a write only, −1 for a read only, 0 for both or neither.
- `empty` = (count == 0); `full` = (count == depth); `data_count` = count. All are derived from registered state, so there are no combinational paths from inputs.
- `dout` = memory[`rp`] when not empty, and all-zeros when empty. This gives a deterministic value for verification.
- Pointers wrap naturally; no word is ever lost or duplicated across the wrap.
- Reset:
  - `wp` = `rp` = count = 0, giving `empty`=1, `full`=0, `data_count`=0, `dout`=0.
  - Memory contents are not cleared.
  - Reset has priority over any simultaneous `wr_en`/`rd_en`.
  - Reset asserted mid-operation discards all stored data at that edge.

## Timing
- Write to visibility: a write accepted at edge N makes `empty` fall and the word appear on `dout` immediately after edge N. This holds when the FIFO was empty, a 1-cycle latency.
- Read: `rd_en` sampled at edge N pops the word. The next word, or zeros plus `empty`=1, is on `dout` after edge N. The popped word was valid on `dout` during the cycle before edge N.
- `full` rises after the edge that accepts the 16th unread word. It falls after the first accepted read.
- `data_count` reflects every accepted operation after the same edge.
- Back-to-back reads or writes are sustained at one per cycle with no bubbles.

## Test plan
- Reset: hold `rst`=1 for 1 cycle, then release. Required: `empty`=1, `full`=0, `data_count`=0, `dout`=0.
- Single fall-through: write 0x12 for one cycle. Required:
  - Next cycle `dout`=0x12, `empty`=0, `data_count`=1.
  - Then pulse `rd_en` for 1 cycle; required `empty`=1, `data_count`=0.
- Ordering: write 0x25, idle 2 cycles, write 0x37 then 0x11. Required: `data_count`=3. Then hold `rd_en` for 3 cycles; `dout` must show 0x25, 0x37, 0x11 in order, then `empty`=1.
- Overflow: write 19 consecutive words 0x11, 0x22, …, 0x99, 0x15, 0x26, 0x54, 0x87, 0x65, 0x32, 0x54, 0x58, 0x56, 0x14. Required:
  - `full`=1 and `data_count`=16 after the 16th write.
  - The last 3 words (0x58, 0x56, 0x14) are dropped.
- Drain and underflow: hold `rd_en` for 20 cycles. Required:
  - `dout` yields exactly the first 16 words in order, and `full` drops after the first pop.
  - `empty`=1 and `data_count`=0 afterward; extra reads leave the count at 0.
- Corners: at full, assert `rd_en` and `wr_en` together; required: count 15, new word dropped. At empty, assert both; required: count 1, word visible on `dout`. Assert `rst` while 5 words are stored; required: empty state after that edge.

Source files
------------

// File: rtl/fwft_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: the oldest word is always on dout,
// and rd_en acknowledges (pops) it. Occupancy is exported for flow control.
module fwft_sync_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   data_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [CNT_W-1:0]      count;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance is decided from the pre-edge flags, so full+rd and empty+wr resolve cleanly.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Pointer and occupancy state; reset discards stored data but leaves memory untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + DEPTH_LOG2'(1);
            end
            if (rd_ok) begin
                rp <= rp + DEPTH_LOG2'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wp] <= din;
        end
    end

    // Flags and data all come straight from registered state; no input-to-output paths.
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign data_count = count;
    assign dout       = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Self-checking bench for fwft_sync_fifo: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_fwft_sync_fifo;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic [4:0]       data_count;

    int total;
    int bad;

    fwft_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .din        (din),
        .full       (full),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic        rd;
        logic [31:0] d;
        logic [31:0] exp_dout;
        logic        exp_empty;
        logic        exp_full;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [31:0] d,
                                input logic [31:0] ed, input logic ee, input logic ef, input logic [4:0] ec);
        vec_t v;
        v.r = r; v.w = w; v.rd = rd; v.d = d;
        v.exp_dout = ed; v.exp_empty = ee; v.exp_full = ef; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [31:0] ed, input logic ee,
                             input logic ef, input logic [4:0] ec);
        chk({name, ".dout"}, dout, ed);
        chk({name, ".empty"}, 32'(empty), 32'(ee));
        chk({name, ".full"}, 32'(full), 32'(ef));
        chk({name, ".count"}, 32'(data_count), 32'(ec));
    endtask

    // Drive for one edge, then sample 1 time unit after it with inputs returned to idle.
    task automatic step(input logic r, input logic w, input logic rd, input logic [31:0] d);
        rst = r; wr_en = w; rd_en = rd; din = d;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    logic [31:0] words[19];
    logic [31:0] q[$];
    logic [31:0] exp_d;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        // Directed table: reset, fall-through, ordering, empty corner, underflow.
        vecs[0]  = mk(1, 0, 0, 32'h00, 32'h00, 1, 0, 5'd0);
        vecs[1]  = mk(0, 1, 0, 32'h12, 32'h12, 0, 0, 5'd1);
        vecs[2]  = mk(0, 0, 1, 32'h00, 32'h00, 1, 0, 5'd0);
        vecs[3]  = mk(0, 1, 0, 32'h25, 32'h25, 0, 0, 5'd1);
        vecs[4]  = mk(0, 0, 0, 32'h00, 32'h25, 0, 0, 5'd1);
        vecs[5]  = mk(0, 0, 0, 32'h00, 32'h25, 0, 0, 5'd1);
        vecs[6]  = mk(0, 1, 0, 32'h37, 32'h25, 0, 0, 5'd2);
        vecs[7]  = mk(0, 1, 0, 32'h11, 32'h25, 0, 0, 5'd3);
        vecs[8]  = mk(0, 0, 1, 32'h00, 32'h37, 0, 0, 5'd2);
        vecs[9]  = mk(0, 0, 1, 32'h00, 32'h11, 0, 0, 5'd1);
        vecs[10] = mk(0, 0, 1, 32'h00, 32'h00, 1, 0, 5'd0);
        vecs[11] = mk(0, 1, 1, 32'h5A, 32'h5A, 0, 0, 5'd1);
        vecs[12] = mk(0, 0, 1, 32'h00, 32'h00, 1, 0, 5'd0);
        vecs[13] = mk(0, 0, 1, 32'h00, 32'h00, 1, 0, 5'd0);

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].d);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_empty,
                      vecs[i].exp_full, vecs[i].exp_cnt);
        end

        // Overflow: 19 writes, last three must be dropped.
        words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99,
                  32'h15, 32'h26, 32'h54, 32'h87, 32'h65, 32'h32, 32'h54, 32'h58, 32'h56, 32'h14};
        for (int i = 0; i < 19; i++) begin
            step(0, 1, 0, words[i]);
            if (i == 14) chk("ovf.full_before_16th", 32'(full), 32'd0);
            if (i == 15) chk("ovf.full_at_16th", 32'(full), 32'd1);
        end
        chk_state("ovf.end", 32'h11, 0, 1, 5'd16);

        // Drain with underflow reads.
        for (int i = 0; i < 20; i++) begin
            if (i < 16) chk($sformatf("drain.dout%0d", i), dout, words[i]);
            step(0, 0, 1, 32'h0);
            if (i == 0) chk("drain.full_drop", 32'(full), 32'd0);
        end
        chk_state("drain.end", 32'h0, 1, 0, 5'd0);

        // Full corner: simultaneous read+write at full pops and drops the new word.
        for (int i = 0; i < 16; i++) step(0, 1, 0, words[i]);
        step(0, 1, 1, 32'hEE);
        chk_state("fullrw", words[1], 0, 0, 5'd15);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fullrw.dout%0d", i), dout, words[i]);
            step(0, 0, 1, 32'h0);
        end
        chk_state("fullrw.end", 32'h0, 1, 0, 5'd0);

        // Reset with 5 words stored, and with a write requested on the same edge.
        for (int i = 0; i < 5; i++) step(0, 1, 0, words[i]);
        chk("rst5.pre_count", 32'(data_count), 32'd5);
        step(1, 1, 1, 32'hAB);
        chk_state("rst5", 32'h0, 1, 0, 5'd0);

        // Random traffic against a queue model.
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, w, rd;
            logic [31:0] d;
            int sz;
            r  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 50);
            d  = $urandom;
            sz = q.size();
            if (r) begin
                q.delete();
            end else begin
                if (rd && sz > 0) void'(q.pop_front());
                if (w && sz < int'(DEPTH)) q.push_back(d);
            end
            step(r, w, rd, d);
            exp_d = (q.size() > 0) ? q[0] : 32'h0;
            chk_state($sformatf("rnd%0d", cyc), exp_d, q.size() == 0,
                      q.size() == int'(DEPTH), 5'(q.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
